// File: rtl/ifid_queue.sv
// ifid_queue: instruction/PC queue between fetch and the ID/EX register.
// Fetch pushes on ihit, decode pops the head on wen, a control-flow flush
// empties the queue. An empty queue presents an all-zero NOP.
// Optional feature: define IFQ_BYPASS_EN to forward a fetch into an empty
// queue straight to the outputs in the same cycle.
//
// Ports:
//   clk            in   pipeline clock
//   nRst           in   synchronous active-high reset
//   ihit           in   push request
//   imemload_input in   fetched instruction word
//   imemaddr_input in   PC of fetched instruction
//   wen            in   pop request (ID/EX latching the head)
//   flushed        in   discard all entries
//   imemload       out  head instruction, 0 when empty
//   imemaddr       out  head PC, 0 when empty
//   valid          out  head holds a real instruction
//   full           out  occupancy == DEPTH
//   count          out  current occupancy
module ifid_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic            ihit,
  input  logic [31:0]     imemload_input,
  input  logic [31:0]     imemaddr_input,
  input  logic            wen,
  input  logic            flushed,
  output logic [31:0]     imemload,
  output logic [31:0]     imemaddr,
  output logic            valid,
  output logic            full,
  output logic [CNTW-1:0] count
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]     mem_q [DEPTH];
  logic [63:0]     mem_d [DEPTH];
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic q_valid;
  logic q_full;
  logic pop;
  logic push;
  logic byp;
  logic byp_take;

  // Effective push/pop qualification from registered occupancy
  always_comb begin
    q_valid = (count_q != '0);
    q_full  = (count_q == CNTW'(DEPTH));
    pop     = wen & q_valid;
    push    = ihit & (~q_full | pop);
`ifdef IFQ_BYPASS_EN
    byp      = ~q_valid & ihit & ~flushed;
    byp_take = byp & wen;
`else
    byp      = 1'b0;
    byp_take = 1'b0;
`endif
  end

  // Next-state: flush beats push/pop; a bypassed-and-consumed fetch touches nothing
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flushed) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (!byp_take) begin
      if (push) begin
        mem_d[wr_ptr_q] = {imemload_input, imemaddr_input};
        wr_ptr_d        = wr_ptr_q + PTRW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy state with synchronous reset
  always_ff @(posedge clk) begin
    if (nRst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care whenever count says empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head presentation: NOP when empty, forwarded fetch when bypassing
  always_comb begin
    imemload = '0;
    imemaddr = '0;
    valid    = q_valid;
    if (q_valid) begin
      {imemload, imemaddr} = mem_q[rd_ptr_q];
    end
    if (byp) begin
      imemload = imemload_input;
      imemaddr = imemaddr_input;
      valid    = 1'b1;
    end
    full  = q_full;
    count = count_q;
  end

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_ifid_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 3;

  logic            clk;
  logic            nRst;
  logic            ihit;
  logic [31:0]     imemload_input;
  logic [31:0]     imemaddr_input;
  logic            wen;
  logic            flushed;
  logic [31:0]     imemload;
  logic [31:0]     imemaddr;
  logic            valid;
  logic            full;
  logic [CNTW-1:0] count;

  int errors;
  int checks;

  ifid_queue #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .nRst(nRst), .ihit(ihit),
    .imemload_input(imemload_input), .imemaddr_input(imemaddr_input),
    .wen(wen), .flushed(flushed),
    .imemload(imemload), .imemaddr(imemaddr),
    .valid(valid), .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO of {instr, pc} entries
  logic [63:0] mq[$];

  typedef struct {
    logic        ih;
    logic [31:0] ld;
    logic [31:0] ad;
    logic        w;
    logic        fl;
    logic [68:0] exp;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [68:0] ov(input logic [31:0] l, input logic [31:0] a,
                                     input logic v, input logic f, input logic [2:0] c);
    return {l, a, v, f, c};
  endfunction

  function automatic vec_t mk(input logic ih, input logic [31:0] ld, input logic [31:0] ad,
                              input logic w, input logic fl, input logic [68:0] e);
    vec_t t;
    t.ih = ih; t.ld = ld; t.ad = ad; t.w = w; t.fl = fl; t.exp = e;
    return t;
  endfunction

  function automatic logic [68:0] dut_vec();
    return {imemload, imemaddr, valid, full, count};
  endfunction

  // Expected outputs for the current cycle given model contents and inputs
  function automatic logic [68:0] model_vec();
    logic byp;
`ifdef IFQ_BYPASS_EN
    byp = (mq.size() == 0) && ihit && !flushed;
`else
    byp = 1'b0;
`endif
    if (byp)
      return ov(imemload_input, imemaddr_input, 1'b1, 1'b0, 3'd0);
    if (mq.size() > 0)
      return {mq[0], 1'b1, (mq.size() == DEPTH), 3'(mq.size())};
    return 69'h0;
  endfunction

  // Model state update at a rising edge
  task automatic model_edge();
    logic do_pop, do_push, byp_take;
    if (nRst || flushed) begin
      mq.delete();
    end else begin
`ifdef IFQ_BYPASS_EN
      byp_take = (mq.size() == 0) && ihit && wen;
`else
      byp_take = 1'b0;
`endif
      if (!byp_take) begin
        do_pop  = wen && (mq.size() > 0);
        do_push = ihit && ((mq.size() < DEPTH) || do_pop);
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back({imemload_input, imemaddr_input});
      end
    end
  endtask

  task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got load=%h addr=%h v=%b f=%b c=%0d, expected load=%h addr=%h v=%b f=%b c=%0d",
               nm, act[68:37], act[36:5], act[4], act[3], act[2:0],
               exp[68:37], exp[36:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic drive(input logic r, input logic ih, input logic [31:0] ld,
                       input logic [31:0] ad, input logic w, input logic fl);
    @(negedge clk);
    nRst = r; ihit = ih; imemload_input = ld; imemaddr_input = ad; wen = w; flushed = fl;
    #1;
  endtask

  task automatic edge_upd();
    @(posedge clk);
    model_edge();
  endtask

  task automatic step(input logic r, input logic ih, input logic [31:0] ld,
                      input logic [31:0] ad, input logic w, input logic fl, input string nm);
    drive(r, ih, ld, ad, w, fl);
    chk(nm, dut_vec(), model_vec());
    edge_upd();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    edge_upd();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    nRst = 1'b1; ihit = 1'b0; imemload_input = '0; imemaddr_input = '0;
    wen = 1'b0; flushed = 1'b0;

    // Directed table: reset/idle, three pushes, three pops, pop-on-empty
    tbl[0] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ov(32'h0, 32'h0, 1'b0, 1'b0, 3'd0));
`ifdef IFQ_BYPASS_EN
    tbl[1] = mk(1'b1, 32'h8C220004, 32'h0, 1'b0, 1'b0, ov(32'h8C220004, 32'h0, 1'b1, 1'b0, 3'd0));
`else
    tbl[1] = mk(1'b1, 32'h8C220004, 32'h0, 1'b0, 1'b0, ov(32'h0, 32'h0, 1'b0, 1'b0, 3'd0));
`endif
    tbl[2] = mk(1'b1, 32'h00000000, 32'h4, 1'b0, 1'b0, ov(32'h8C220004, 32'h0, 1'b1, 1'b0, 3'd1));
    tbl[3] = mk(1'b1, 32'h20010001, 32'h8, 1'b0, 1'b0, ov(32'h8C220004, 32'h0, 1'b1, 1'b0, 3'd2));
    tbl[4] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, ov(32'h8C220004, 32'h0, 1'b1, 1'b0, 3'd3));
    tbl[5] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, ov(32'h00000000, 32'h4, 1'b1, 1'b0, 3'd2));
    tbl[6] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, ov(32'h20010001, 32'h8, 1'b1, 1'b0, 3'd1));
    tbl[7] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ov(32'h0, 32'h0, 1'b0, 1'b0, 3'd0));
    tbl[8] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, ov(32'h0, 32'h0, 1'b0, 1'b0, 3'd0));
    tbl[9] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ov(32'h0, 32'h0, 1'b0, 1'b0, 3'd0));

    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, tbl[i].ih, tbl[i].ld, tbl[i].ad, tbl[i].w, tbl[i].fl);
      chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
      edge_upd();
    end

    // Fill to full (pointers wrap since wr_ptr starts at 3), drop while full,
    // then push+pop at full
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h1000 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0, $sformatf("fill%0d", i));
    step(1'b0, 1'b1, 32'hDEAD, 32'h200, 1'b0, 1'b0, "push_when_full");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("drop_at_full", dut_vec(), ov(32'h1000, 32'h100, 1'b1, 1'b1, 3'd4));
    edge_upd();
    step(1'b0, 1'b1, 32'hF00D, 32'h300, 1'b1, 1'b0, "push_pop_full");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("head_after_push_pop", dut_vec(), ov(32'h1001, 32'h104, 1'b1, 1'b1, 3'd4));
    edge_upd();
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, $sformatf("drain%0d", i));
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("drained", dut_vec(), ov(32'h0, 32'h0, 1'b0, 1'b0, 3'd0));
    edge_upd();

    // Flush with simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h2000 + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0, $sformatf("pre_flush%0d", i));
    step(1'b0, 1'b1, 32'hBEEF, 32'h500, 1'b1, 1'b1, "flush_cycle");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("after_flush", dut_vec(), ov(32'h0, 32'h0, 1'b0, 1'b0, 3'd0));
    edge_upd();

    // Fetch into empty queue with simultaneous wen
    do_reset();
    drive(1'b0, 1'b1, 32'h3C010010, 32'h40, 1'b1, 1'b0);
`ifdef IFQ_BYPASS_EN
    chk("empty_fetch_same_cycle", dut_vec(), ov(32'h3C010010, 32'h40, 1'b1, 1'b0, 3'd0));
`else
    chk("empty_fetch_same_cycle", dut_vec(), ov(32'h0, 32'h0, 1'b0, 1'b0, 3'd0));
`endif
    edge_upd();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef IFQ_BYPASS_EN
    chk("empty_fetch_next_cycle", dut_vec(), ov(32'h0, 32'h0, 1'b0, 1'b0, 3'd0));
`else
    chk("empty_fetch_next_cycle", dut_vec(), ov(32'h3C010010, 32'h40, 1'b1, 1'b0, 3'd1));
`endif
    edge_upd();

    // Randomized traffic against the model, with varying pop pressure
    for (int i = 0; i < 1500; i++) begin
      int unsigned wpct;
      wpct = 20 + 30 * ((i / 250) % 3);
      step(($urandom % 64) == 0, ($urandom % 4) != 0, $urandom, $urandom,
           $urandom_range(0, 99) < wpct, ($urandom % 32) == 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
